// File: rtl/medidor_distancia_hcsr04.sv
// HC-SR04 ultrasonic distance meter: fires a trigger pulse, times the echo
// and reports the distance in centimetres as three saturating BCD digits.
//
// Ports:
//   clock      system clock, rising edge
//   reset_n    synchronous active-low reset
//   medir      start request, only honoured while idle (OCIOSO)
//   echo       asynchronous echo line from the sensor
//   trigger    registered trigger pulse to the sensor
//   unidades   BCD units of the last valid distance (cm)
//   dezenas    BCD tens
//   centenas   BCD hundreds
//   pronto     one-cycle completion pulse
//   erro       one-cycle timeout flag, coincident with pronto
//   db_estado  current FSM state code (debug)

module medidor_distancia_hcsr04 #(
    parameter int TRIG_CYCLES    = 500,
    parameter int CYCLES_PER_CM  = 2941,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       medir,
    input  logic       echo,
    output logic       trigger,
    output logic [3:0] unidades,
    output logic [3:0] dezenas,
    output logic [3:0] centenas,
    output logic       pronto,
    output logic       erro,
    output logic [2:0] db_estado
);

    localparam int TW = $clog2(TRIG_CYCLES + 1);
    localparam int CW = $clog2(CYCLES_PER_CM + 1);
    localparam int OW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] CPC_LAST  = CW'(CYCLES_PER_CM - 1);
    localparam logic [OW-1:0] TMO_LAST  = OW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        DISPARA     = 3'd1,
        ESPERA_ECHO = 3'd2,
        MEDE        = 3'd3,
        ARMAZENA    = 3'd4,
        FINAL       = 3'd5
    } estado_t;

    estado_t       estado, estado_n;
    logic          echo_m, echo_s;
    logic [TW-1:0] trig_cnt, trig_cnt_n;
    logic [CW-1:0] cyc_cnt, cyc_cnt_n;
    logic [OW-1:0] tmo_cnt, tmo_cnt_n;
    logic [11:0]   acc, acc_n;
    logic [11:0]   res, res_n;
    logic          err_q, err_n;

    // Saturating three-digit BCD increment {hundreds, tens, units}.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v == 12'h999) begin
            r = v;
        end else if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else if (v[7:4] != 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = v[7:4] + 4'd1;
        end else begin
            r[3:0]  = 4'd0;
            r[7:4]  = 4'd0;
            r[11:8] = v[11:8] + 4'd1;
        end
        return r;
    endfunction

    always_comb begin
        estado_n   = estado;
        trig_cnt_n = trig_cnt;
        cyc_cnt_n  = cyc_cnt;
        tmo_cnt_n  = tmo_cnt;
        acc_n      = acc;
        res_n      = res;
        err_n      = err_q;
        unique case (estado)
            OCIOSO: begin
                if (medir) begin
                    estado_n   = DISPARA;
                    trig_cnt_n = '0;
                    cyc_cnt_n  = '0;
                    tmo_cnt_n  = '0;
                    acc_n      = '0;
                    err_n      = 1'b0;
                end
            end
            DISPARA: begin
                if (trig_cnt == TRIG_LAST) begin
                    estado_n  = ESPERA_ECHO;
                    tmo_cnt_n = '0;
                end else begin
                    trig_cnt_n = trig_cnt + 1'b1;
                end
            end
            ESPERA_ECHO: begin
                // The cycle that detects echo high is itself an echo-high
                // cycle, so it is counted like the ones in MEDE.
                if (echo_s) begin
                    estado_n  = MEDE;
                    tmo_cnt_n = '0;
                    if (cyc_cnt == CPC_LAST) begin
                        cyc_cnt_n = '0;
                        acc_n     = bcd_inc(acc);
                    end else begin
                        cyc_cnt_n = cyc_cnt + 1'b1;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    estado_n = FINAL;
                    err_n    = 1'b1;
                end else begin
                    tmo_cnt_n = tmo_cnt + 1'b1;
                end
            end
            MEDE: begin
                if (!echo_s) begin
                    estado_n = ARMAZENA;
                end else if (tmo_cnt == TMO_LAST) begin
                    estado_n = FINAL;
                    err_n    = 1'b1;
                end else begin
                    tmo_cnt_n = tmo_cnt + 1'b1;
                    if (cyc_cnt == CPC_LAST) begin
                        cyc_cnt_n = '0;
                        acc_n     = bcd_inc(acc);
                    end else begin
                        cyc_cnt_n = cyc_cnt + 1'b1;
                    end
                end
            end
            ARMAZENA: begin
                res_n    = acc;
                estado_n = FINAL;
            end
            FINAL: begin
                estado_n = OCIOSO;
            end
            default: begin
                estado_n = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado   <= OCIOSO;
            echo_m   <= 1'b0;
            echo_s   <= 1'b0;
            trig_cnt <= '0;
            cyc_cnt  <= '0;
            tmo_cnt  <= '0;
            acc      <= '0;
            res      <= '0;
            err_q    <= 1'b0;
            trigger  <= 1'b0;
        end else begin
            estado   <= estado_n;
            echo_m   <= echo;
            echo_s   <= echo_m;
            trig_cnt <= trig_cnt_n;
            cyc_cnt  <= cyc_cnt_n;
            tmo_cnt  <= tmo_cnt_n;
            acc      <= acc_n;
            res      <= res_n;
            err_q    <= err_n;
            // Registered from the next state so it is high exactly
            // during the DISPARA cycles without decode glitches.
            trigger  <= (estado_n == DISPARA);
        end
    end

    assign pronto    = (estado == FINAL);
    assign erro      = (estado == FINAL) && err_q;
    assign unidades  = res[3:0];
    assign dezenas   = res[7:4];
    assign centenas  = res[11:8];
    assign db_estado = estado;

endmodule
